// File: rtl/mem_access.sv
// Byte-serial load/store engine between the EX/MEM register and an 8-bit RAM port.
// Optional alignment check enabled by defining MEM_MISALIGN_CHK_EN.
module mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_ld,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_wd,
    input  logic              req_wreg,
    output logic              stall_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

    state_t      state;
    logic [2:0]  k;
    logic [2:0]  nbytes;
    logic [31:0] data_q;
    logic [31:0] load_word;
    logic [31:0] load_ext;
    logic        mis;
    logic        accept;
    logic        issue;
    logic        write;

    always_comb begin
        case (req_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

`ifdef MEM_MISALIGN_CHK_EN
    assign mis = ((req_size == 2'b01) & req_addr[0]) |
                 (req_size[1] & (req_addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Gating with rst forces the combinational outputs low while reset is held.
    assign accept  = rst & (state == IDLE) & req_valid;
    assign issue   = (accept & ~mis) | ((state == LOAD) & (k < nbytes)) | (state == STORE);
    assign write   = (accept & ~mis & ~req_ld) | (state == STORE);
    assign stall_o = accept | (state == LOAD) | (state == STORE);

    assign ram_addr_o = issue ? req_addr + ADDR_W'(k) : '0;
    assign ram_wr_o   = write;
    assign ram_dout_o = write ? 8'(req_wdata >> {k[1:0], 3'b000}) : 8'h00;

    // RAM returns the byte addressed in the previous cycle, so LOAD at count k fills byte k-1.
    always_comb begin
        load_word = data_q;
        case (k)
            3'd1:    load_word[7:0]   = ram_din_i;
            3'd2:    load_word[15:8]  = ram_din_i;
            3'd3:    load_word[23:16] = ram_din_i;
            default: load_word[31:24] = ram_din_i;
        endcase
    end

    always_comb begin
        case (req_size)
            2'b00:   load_ext = req_unsigned ? {24'b0, load_word[7:0]}
                                             : {{24{load_word[7]}}, load_word[7:0]};
            2'b01:   load_ext = req_unsigned ? {16'b0, load_word[15:0]}
                                             : {{16{load_word[15]}}, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            k       <= 3'd0;
            data_q  <= 32'b0;
            done_o  <= 1'b0;
            rdata_o <= 32'b0;
            wd_o    <= 5'b0;
            wreg_o  <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            rdata_o <= 32'b0;
            wreg_o  <= 1'b0;
            case (state)
                IDLE: begin
                    k <= 3'd0;
                    if (req_valid) begin
                        wd_o <= req_wd;
                        if (mis || (!req_ld && nbytes == 3'd1)) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= req_ld ? LOAD : STORE;
                            k     <= 3'd1;
                        end
                    end
                end
                LOAD: begin
                    data_q <= load_word;
                    if (k == nbytes) begin
                        state   <= DONE;
                        k       <= 3'd0;
                        done_o  <= 1'b1;
                        rdata_o <= load_ext;
                        wreg_o  <= req_wreg;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                STORE: begin
                    if (k == nbytes - 3'd1) begin
                        state  <= DONE;
                        k      <= 3'd0;
                        done_o <= 1'b1;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    k     <= 3'd0;
                end
            endcase
        end
    end

`ifdef MEM_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= accept & mis;
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, back-to-back RAW, mid-access reset, misalignment.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ld;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_wd;
    logic        req_wreg;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic        misalign_o;
    logic [31:0] ram_addr_o;
    logic [7:0]  ram_dout_o;
    logic        ram_wr_o;
    logic [7:0]  ram_din_i;

    logic [7:0]  mem [0:1023];

    int checks = 0;
    int errors = 0;

    int          lat;
    logic        stall_hi;
    logic [31:0] d_rdata;
    logic        d_wreg;
    logic [4:0]  d_wd;
    logic        d_mis;
    logic        d_stall;
    logic [31:0] log_addr [0:19];
    logic        log_wr   [0:19];
    logic [7:0]  log_dout [0:19];

    mem_access #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ld(req_ld),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wd(req_wd), .req_wreg(req_wreg),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .wd_o(wd_o),
        .wreg_o(wreg_o), .misalign_o(misalign_o), .ram_addr_o(ram_addr_o),
        .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o), .ram_din_i(ram_din_i)
    );

    always #5 clk = ~clk;

    // RAM: one-cycle read latency, write on the strobe.
    always @(posedge clk) begin
        if (ram_wr_o) mem[ram_addr_o[9:0]] <= ram_dout_o;
        ram_din_i <= mem[ram_addr_o[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; logs each cycle until done_o (bounded to 20 cycles).
    task automatic run_req(input logic ld, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdat,
                           input logic [4:0] wd, input logic wreg);
        req_valid = 1'b1; req_ld = ld; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdat; req_wd = wd; req_wreg = wreg;
        lat = -1; stall_hi = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            log_addr[c] = ram_addr_o;
            log_wr[c]   = ram_wr_o;
            log_dout[c] = ram_dout_o;
            if (done_o) begin
                lat = c; d_rdata = rdata_o; d_wreg = wreg_o; d_wd = wd_o;
                d_mis = misalign_o; d_stall = stall_o;
                break;
            end
            if (!stall_o) stall_hi = 1'b0;
            @(negedge clk);
        end
        if (lat < 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            lat = 0;
        end
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h55;
        mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
        mem[10'h104] = 8'hAB; mem[10'h105] = 8'hCD;
        mem[10'h200] = 8'h80; mem[10'h201] = 8'h9A;

        rst = 1'b0; req_valid = 1'b0; req_ld = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_wd = 5'd0; req_wreg = 1'b0;
        #2;
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_ram_addr", ram_addr_o, 32'd0);
        chk("rst_ram_wr", {31'b0, ram_wr_o}, 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        #1 chk("idle_quiet_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);

        // LW 0x100
        run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1);
        chk("lw_latency", lat, 32'd5);
        chk("lw_rdata", d_rdata, 32'h12345678);
        chk("lw_wreg", {31'b0, d_wreg}, 32'd1);
        chk("lw_wd", {27'b0, d_wd}, 32'd7);
        chk("lw_stall_busy", {31'b0, stall_hi}, 32'd1);
        chk("lw_stall_done", {31'b0, d_stall}, 32'd0);
        chk("lw_mis", {31'b0, d_mis}, 32'd0);
        chk("lw_addr0", log_addr[0], 32'h100);
        chk("lw_addr3", log_addr[3], 32'h103);
        chk("lw_addr4_quiet", log_addr[4], 32'h0);
        chk("lw_no_write", {31'b0, log_wr[0] | log_wr[1] | log_wr[2] | log_wr[3]}, 32'd0);
        idle_cycle();
        #1;
        chk("after_done_idle_stall", {31'b0, stall_o}, 32'd0);
        chk("after_done_rdata", rdata_o, 32'd0);
        chk("after_done_wreg", {31'b0, wreg_o}, 32'd0);
        @(negedge clk);

        // LB / LBU / LH / LHU at 0x200
        run_req(1'b1, 2'b00, 1'b0, 32'h200, 32'h0, 5'd3, 1'b1);
        chk("lb_latency", lat, 32'd2);
        chk("lb_rdata", d_rdata, 32'hFFFFFF80);
        idle_cycle();
        run_req(1'b1, 2'b00, 1'b1, 32'h200, 32'h0, 5'd3, 1'b1);
        chk("lbu_rdata", d_rdata, 32'h00000080);
        idle_cycle();
        run_req(1'b1, 2'b01, 1'b0, 32'h200, 32'h0, 5'd4, 1'b0);
        chk("lh_latency", lat, 32'd3);
        chk("lh_rdata", d_rdata, 32'hFFFF9A80);
        chk("lh_wreg_off", {31'b0, d_wreg}, 32'd0);
        idle_cycle();
        run_req(1'b1, 2'b01, 1'b1, 32'h200, 32'h0, 5'd4, 1'b1);
        chk("lhu_rdata", d_rdata, 32'h00009A80);
        idle_cycle();

        // SH 0xCAFEBEEF to 0x300
        run_req(1'b0, 2'b01, 1'b0, 32'h300, 32'hCAFEBEEF, 5'd9, 1'b1);
        chk("sh_latency", lat, 32'd2);
        chk("sh_wr0", {log_wr[0], 15'b0, log_addr[0][15:0]}, {1'b1, 15'b0, 16'h0300});
        chk("sh_dout0", {24'b0, log_dout[0]}, 32'hEF);
        chk("sh_wr1", {log_wr[1], 15'b0, log_addr[1][15:0]}, {1'b1, 15'b0, 16'h0301});
        chk("sh_dout1", {24'b0, log_dout[1]}, 32'hBE);
        chk("sh_no_wr_done", {31'b0, log_wr[2]}, 32'd0);
        chk("sh_rdata", d_rdata, 32'd0);
        chk("sh_wreg", {31'b0, d_wreg}, 32'd0);
        idle_cycle();
        chk("sh_mem", {mem[10'h302], mem[10'h301], mem[10'h300]}, 32'h0055BEEF);

        // SW then LW back-to-back on the same address
        run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 5'd1, 1'b0);
        chk("sw_latency", lat, 32'd4);
        req_ld = 1'b1; req_addr = 32'h40; req_wd = 5'd12; req_wreg = 1'b1;
        #1;
        chk("sw_done_ignores_req", {30'b0, stall_o, ram_wr_o}, 32'd0);
        @(negedge clk);
        run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 5'd12, 1'b1);
        chk("raw_accept_addr", log_addr[0], 32'h40);
        chk("raw_latency", lat, 32'd5);
        chk("raw_rdata", d_rdata, 32'hDEADBEEF);
        idle_cycle();

        // Reset during a LW at T2
        req_valid = 1'b1; req_ld = 1'b1; req_size = 2'b10; req_addr = 32'h100;
        req_wd = 5'd21; req_wreg = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_stall", {31'b0, stall_o}, 32'd0);
        chk("midrst_ram_addr", ram_addr_o, 32'd0);
        chk("midrst_wd", {27'b0, wd_o}, 32'd0);
        chk("midrst_misc", {28'b0, done_o, wreg_o, misalign_o, ram_wr_o}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        #1 chk("postrst_idle", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        run_req(1'b1, 2'b00, 1'b1, 32'h101, 32'h0, 5'd2, 1'b1);
        chk("postrst_lbu", d_rdata, 32'h00000056);
        idle_cycle();

        // Misaligned LW at 0x102
        run_req(1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 5'd6, 1'b1);
`ifdef MEM_MISALIGN_CHK_EN
        chk("mis_latency", lat, 32'd1);
        chk("mis_flag", {31'b0, d_mis}, 32'd1);
        chk("mis_wreg", {31'b0, d_wreg}, 32'd0);
        chk("mis_rdata", d_rdata, 32'd0);
        chk("mis_no_ram", {log_wr[0], log_addr[0][30:0]}, 32'd0);
`else
        chk("mis_latency", lat, 32'd5);
        chk("mis_rdata", d_rdata, 32'hCDAB1234);
        chk("mis_flag", {31'b0, d_mis}, 32'd0);
        chk("mis_addr3", log_addr[3], 32'h105);
`endif
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
